// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared state type, frame sizes and Hamming(7,4) bit positions
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int CW_BITS    = 7;
    localparam int FRAME_BITS = 30;
    localparam int DATA_BITS  = 28;

    // Codeword bit index = Hamming position - 1
    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D0_POS = 2;
    localparam int P4_POS = 3;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;

endpackage

// File: rtl/hamming74_encode.sv
// rtl/hamming74_encode.sv - combinational Hamming(7,4) encoder, cw[0] = position 1
module hamming74_encode
    import hamming_pkg::*;
(
    input  logic [3:0]         data,
    output logic [CW_BITS-1:0] cw
);

    always_comb begin
        cw         = '0;
        cw[P1_POS] = data[0] ^ data[1] ^ data[3];
        cw[P2_POS] = data[0] ^ data[2] ^ data[3];
        cw[D0_POS] = data[0];
        cw[P4_POS] = data[1] ^ data[2] ^ data[3];
        cw[D1_POS] = data[1];
        cw[D2_POS] = data[2];
        cw[D3_POS] = data[3];
    end

endmodule

// File: rtl/hamming_frame_tx.sv
// rtl/hamming_frame_tx.sv - serialises four Hamming(7,4) codewords between start and stop bits
module hamming_frame_tx
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        tx_out,
    output logic        busy,
    output logic        frame_done
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        IDX_LAST = 5'(DATA_BITS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic [4:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   encoded;
    logic                   accept;
    logic                   bit_end;
    logic                   last_data;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign bit_end   = (bit_cnt == CNT_LAST);
    assign last_data = (bit_idx == IDX_LAST);

    // nibble0's codeword sits in the low bits so it shifts out first
    for (genvar i = 0; i < 4; i++) begin : g_enc
        hamming74_encode u_enc (
            .data (in_data[4*i +: 4]),
            .cw   (encoded[CW_BITS*i +: CW_BITS])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)               state_next = START;
            START:   if (bit_end)              state_next = DATA;
            DATA:    if (bit_end && last_data) state_next = STOP;
            STOP:    if (bit_end)              state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= encoded;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_out  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx_out  <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (last_data) begin
                            tx_out <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            shreg   <= shreg >> 1;
                            tx_out  <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt    <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/hamming_frame_tx.md
HAMMING_FRAME_TX -- requirements
Module: hamming_frame_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 4, clock cycles per serial bit (legal range >= 1).
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  source offers in_data.
REQ-005 SHALL have port: in_ready  output  1  block can accept a word.
REQ-006 SHALL have port: in_data  input  16  four data nibbles; nibble0 = in_data[3:0] ... nibble3 = in_data[15:12].
REQ-007 SHALL have port: tx_out  output  1  serial line, idle high.
REQ-008 SHALL have port: busy  output  1  frame in progress.
REQ-009 SHALL have port: frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-010 SHALL encode each nibble d[3:0] as Hamming(7,4):
- p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3.
- Codeword cw[6:0] = {d3,d2,d1,p4,d0,p2,p1}, i.e. cw[0] = position 1.
REQ-011 SHALL send a 30-bit frame in this order, each bit held exactly CLKS_PER_BIT cycles:
- Start bit 0.
- cw(nibble0) through cw(nibble3), each codeword LSB (cw[0]) first.
- Stop bit 1.
REQ-012 SHALL implement the FSM as follows:
- States: IDLE, START, DATA, STOP.
- IDLE->START on accept.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 28 bits.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-013 SHALL drive in_ready = 1 only in IDLE. A transfer occurs on the rising edge where in_valid && in_ready.
REQ-014 SHALL latch in_data at the transfer edge. Later in_data changes SHALL NOT affect the frame in progress.
REQ-015 SHALL register tx_out. tx_out = 0 starting the cycle after the transfer edge; the frame occupies exactly 30*CLKS_PER_BIT cycles.
REQ-016 SHALL assert busy in START/DATA/STOP and deassert it in IDLE.
REQ-017 SHALL pulse frame_done high for exactly one cycle: the first IDLE cycle after the stop bit. in_ready SHALL also be 1 in that cycle.
REQ-018 SHALL support back-to-back transfers: a word accepted in the frame_done cycle SHALL start its start bit on the next cycle, with no extra idle cycles.
REQ-019 SHALL ignore in_valid while busy (no queuing, no corruption).
REQ-020 SHALL use a bit-period counter sized ceil(log2(CLKS_PER_BIT+1)) and a bit index 0..27 that resets to 0 at every frame start.
REQ-021 SHALL handle CLKS_PER_BIT = 1 as one cycle per bit: a 30-cycle frame with the same ordering.

Reset
REQ-022 SHALL, while rst = 1 and independent of clk, force the following:
- State IDLE.
- tx_out = 1, in_ready = 1, busy = 0, frame_done = 0.
- All counters and the shift register to 0.
REQ-023 SHALL, on reset asserted mid-frame, abort the frame with no stop bit and no frame_done.
REQ-024 SHALL, after reset deasserts, accept a new word on the first clock edge where in_valid = 1.

Structure
REQ-025 SHALL place the following in shared package hamming_pkg:
- State enum.
- CW_BITS = 7, FRAME_BITS = 30, DATA_BITS = 28.
- Codeword bit-position constants.
REQ-026 SHALL use one combinational sub-module, hamming74_encode (4-bit in, 7-bit cw out). It is instantiated four times at the latch point, and the 28 encoded bits are loaded into a shift register.
REQ-027 SHALL produce bit-identical codewords to the team's existing error_correct decoder: a zero-syndrome decode of every cw returns the original nibble.

Verification
REQ-028 SHALL cover: reset idle -> tx_out = 1, in_ready = 1, busy = 0, frame_done = 0 for 10 cycles.
REQ-029 SHALL cover: in_data = 0xF1B0, CLKS_PER_BIT = 4 -> start 0, then codewords 0x00, 0x55, 0x07, 0x7F (LSB first), then stop 1; 120 cycles total; frame_done on cycle 121.
REQ-030 SHALL cover: in_valid held high, two words 0xFFFF then 0x0000 -> second start bit immediately follows the first frame_done cycle; codewords 0x7F x4 then 0x00 x4.
REQ-031 SHALL cover: in_valid pulsed while busy with in_data = 0x1234 -> ignored; frame content unchanged; no second frame.
REQ-032 SHALL cover: rst asserted at bit index 10 -> tx_out = 1 asynchronously, busy = 0, no frame_done; next word 0x000B sends cw 0x55, 0x00, 0x00, 0x00.
REQ-033 SHALL cover: CLKS_PER_BIT = 1, in_data = 0xFFFF -> 30-cycle frame: 0, twenty-eight 1s, 1.
